trigger_scheduler: RTL and testbench

Sequencer in front of the per-channel ADF4030 trigger channels. It accepts trigger-burst requests over a req/ack handshake and aligns every trigger to a BSYNC period boundary derived from `bsync_ratio`. It drives the shared `trigger` line and owns the shadow copies of per-channel enable/phase, so configuration never changes while a channel is aligning a trigger.

---
 rtl/trigger_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_trigger_scheduler.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_scheduler.sv
// trigger_scheduler
// Sequencer in front of the per-channel trigger channels. It accepts burst
// requests over a req/ack handshake, aligns every trigger to a BSYNC period
// boundary and owns the shadow copies of the per-channel enable/phase
// configuration, so that configuration never moves while a trigger is being
// aligned.
//
// Optional feature: define TRIGGER_SCHEDULER_CNT_EN to add the 32-bit
// trig_cnt output, a free-running count of issued trigger pulses.

module trigger_scheduler #(
    parameter int NUM_CH = 4,
    parameter int PH_W   = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   bsync_ready,
    input  logic [PH_W-1:0]        bsync_ratio,
    input  logic [NUM_CH-1:0]      cfg_en,
    input  logic [NUM_CH*PH_W-1:0] cfg_phase,
    input  logic                   cfg_update,
    input  logic                   req,
    input  logic [7:0]             req_count,
    input  logic [PH_W-1:0]        req_interval,
    output logic                   ack,
    input  logic                   abort,
    output logic [NUM_CH-1:0]      ch_en,
    output logic [NUM_CH*PH_W-1:0] ch_phase,
    output logic                   trigger,
    output logic                   busy,
    output logic                   done,
`ifdef TRIGGER_SCHEDULER_CNT_EN
    output logic [31:0]            trig_cnt,
`endif
    output logic [1:0]             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_BSYNC_LOST = 2'd1,
        ERR_ABORTED    = 2'd2
    } err_t;

    // ------------------------------------------------------------------
    // BSYNC period counter
    // ------------------------------------------------------------------
    logic [PH_W-1:0] pcnt;
    logic            sync_valid;
    logic            tick;

    // A ratio below 2 cannot describe a period boundary, so it stalls the
    // counter exactly like a missing BSYNC alignment does.
    assign sync_valid = bsync_ready && (bsync_ratio >= PH_W'(2));
    // '>=' rather than '==' so a ratio that shrinks below the current count
    // still produces a boundary instead of running away.
    assign tick = sync_valid && (pcnt >= (bsync_ratio - PH_W'(1)));

    // Period counter: counts 0..ratio-1 while alignment is valid, else held at 0.
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update from the values present before the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
        end else if (!sync_valid || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PH_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [7:0]      rem_q, rem_d;      // triggers still to issue
    logic [PH_W-1:0] ivl_q, ivl_d;      // BSYNC periods between triggers
    logic [PH_W-1:0] icnt_q, icnt_d;    // ticks seen since the last trigger
    err_t            code_q, code_d;    // completion status held until DONE
    logic            ack_d;
    logic            done_d;
    err_t            err_d;
    logic            fire;

    // Next-state and output decode for the burst sequencer.
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ivl_d   = ivl_q;
        icnt_d  = icnt_q;
        code_d  = code_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = ERR_OK;
        fire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Requests that arrive without a usable BSYNC simply wait.
                if (req && sync_valid) begin
                    ack_d  = 1'b1;
                    rem_d  = req_count;
                    ivl_d  = (req_interval == '0) ? PH_W'(1) : req_interval;
                    icnt_d = '0;
                    code_d = ERR_OK;
                    state_d = (req_count == 8'd0) ? ST_DONE : ST_ALIGN;
                end
            end

            ST_ALIGN, ST_GAP: begin
                // Abort outranks everything, including a tick that would fire.
                if (abort) begin
                    state_d = ST_DONE;
                    code_d  = ERR_ABORTED;
                end else if (!bsync_ready) begin
                    state_d = ST_DONE;
                    code_d  = ERR_BSYNC_LOST;
                end else if (tick) begin
                    // ALIGN fires on the first boundary; GAP on the
                    // interval-th boundary after the previous trigger.
                    if ((state_q == ST_ALIGN) || (icnt_q == (ivl_q - PH_W'(1)))) begin
                        fire = 1'b1;
                    end else begin
                        icnt_d = icnt_q + PH_W'(1);
                    end
                end

                if (fire) begin
                    rem_d   = rem_q - 8'd1;
                    icnt_d  = '0;
                    state_d = (rem_q == 8'd1) ? ST_DONE : ST_GAP;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                err_d   = code_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, burst bookkeeping and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            ivl_q   <= '0;
            icnt_q  <= '0;
            code_q  <= ERR_OK;
            ack     <= 1'b0;
            done    <= 1'b0;
            err     <= 2'd0;
            trigger <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ivl_q   <= ivl_d;
            icnt_q  <= icnt_d;
            code_q  <= code_d;
            ack     <= ack_d;
            done    <= done_d;
            err     <= err_d;
            trigger <= fire;
        end
    end

    // busy follows the state register, so it rises with ack and falls with done.
    assign busy = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Shadow configuration
    // ------------------------------------------------------------------
    logic upd_pend;
    logic upd_apply;

    // While idle or unaligned nothing is timing-critical, so apply at once.
    // During a burst only a boundary that does not fire may move the
    // configuration, so ch_en/ch_phase never change on the trigger edge.
    assign upd_apply = upd_pend &&
                       ((state_q == ST_IDLE) || !bsync_ready || (tick && !fire));

    // Pending-update flag and shadow registers; cfg_* are sampled when applied.
    // NOTE: the shadow registers are reset like any other state so channels
    // come up disabled with a known phase rather than whatever powered up.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            upd_pend <= 1'b0;
            ch_en    <= '0;
            ch_phase <= '0;
        end else begin
            if (cfg_update) begin
                upd_pend <= 1'b1;
            end else if (upd_apply) begin
                upd_pend <= 1'b0;
            end

            if (upd_apply) begin
                ch_en    <= cfg_en;
                ch_phase <= cfg_phase;
            end
        end
    end

`ifdef TRIGGER_SCHEDULER_CNT_EN
    // Count of issued trigger pulses; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_cnt <= '0;
        end else if (fire) begin
            trig_cnt <= trig_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trigger_scheduler.sv
// Self-checking bench for trigger_scheduler. Expected ack/trigger/done events
// are pushed to a scoreboard queue when stimulus is applied; the DUT's events
// are collected on every falling edge and compared at the end of each test.

module tb_trigger_scheduler;

    localparam int NUM_CH = 4;
    localparam int PH_W   = 16;

    localparam logic [1:0] EV_ACK  = 2'd0;
    localparam logic [1:0] EV_TRIG = 2'd1;
    localparam logic [1:0] EV_DONE = 2'd2;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;
        logic [1:0]  err;
    } ev_t;

    logic                   clk;
    logic                   rstn;
    logic                   bsync_ready;
    logic [PH_W-1:0]        bsync_ratio;
    logic [NUM_CH-1:0]      cfg_en;
    logic [NUM_CH*PH_W-1:0] cfg_phase;
    logic                   cfg_update;
    logic                   req;
    logic [7:0]             req_count;
    logic [PH_W-1:0]        req_interval;
    logic                   ack;
    logic                   abort;
    logic [NUM_CH-1:0]      ch_en;
    logic [NUM_CH*PH_W-1:0] ch_phase;
    logic                   trigger;
    logic                   busy;
    logic                   done;
    logic [1:0]             err;
`ifdef TRIGGER_SCHEDULER_CNT_EN
    logic [31:0]            trig_cnt;
`endif

    trigger_scheduler #(.NUM_CH(NUM_CH), .PH_W(PH_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bsync_ready  (bsync_ready),
        .bsync_ratio  (bsync_ratio),
        .cfg_en       (cfg_en),
        .cfg_phase    (cfg_phase),
        .cfg_update   (cfg_update),
        .req          (req),
        .req_count    (req_count),
        .req_interval (req_interval),
        .ack          (ack),
        .abort        (abort),
        .ch_en        (ch_en),
        .ch_phase     (ch_phase),
        .trigger      (trigger),
        .busy         (busy),
        .done         (done),
`ifdef TRIGGER_SCHEDULER_CNT_EN
        .trig_cnt     (trig_cnt),
`endif
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_cmp  = 0;
    int  n_bad  = 0;
    int  cyc    = 0;
    int  m_pcnt = 0;   // reference BSYNC period counter

    function automatic ev_t mk_ev(input logic [1:0] kind, input int c, input logic [1:0] e);
        ev_t ev;
        ev.cyc  = 32'(c);
        ev.kind = kind;
        ev.err  = e;
        return ev;
    endfunction

    // One clock: wait for the falling edge, advance the reference period
    // counter for the rising edge just passed, and record DUT events.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (!rstn) begin
            m_pcnt = 0;
        end else if (!bsync_ready || bsync_ratio < 16'd2 || m_pcnt >= int'(bsync_ratio) - 1) begin
            m_pcnt = 0;
        end else begin
            m_pcnt++;
        end
        if (ack)     obs_q.push_back(mk_ev(EV_ACK, cyc, 2'd0));
        if (trigger) obs_q.push_back(mk_ev(EV_TRIG, cyc, 2'd0));
        if (done)    obs_q.push_back(mk_ev(EV_DONE, cyc, err));
    endtask

    task automatic wait_pcnt(input int p);
        for (int i = 0; i < 64 && m_pcnt != p; i++) step();
    endtask

    task automatic test_reset();
        logic [NUM_CH*PH_W+NUM_CH+5:0] v;
        exp_q.delete();
        obs_q.delete();
        rstn = 1'b0;
        repeat (3) step();
        v = {ack, trigger, busy, done, err, ch_en, ch_phase};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got %h, want 0", v);
        end
        rstn = 1'b1;
        repeat (4) step();
        n_cmp++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b events=%0d, want busy=0 events=0", busy, obs_q.size());
        end
    endtask

    task automatic test_single_burst();
        int  k;
        ev_t e, o;
        exp_q.delete();
        obs_q.delete();
        bsync_ratio = 16'd8;
        wait_pcnt(3);
        k = cyc;
        req = 1'b1; req_count = 8'd1; req_interval = 16'd1;
        exp_q.push_back(mk_ev(EV_ACK, k + 1, 2'd0));
        exp_q.push_back(mk_ev(EV_TRIG, k + 5, 2'd0));
        exp_q.push_back(mk_ev(EV_DONE, k + 6, 2'd0));
        step();
        req = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_busy_rise: busy=%b, want 1", busy);
        end
        while (cyc < k + 16) step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy_fall: busy=%b, want 0", busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_single: got nothing, want kind=%0d cyc=%0d err=%0d", e.kind, e.cyc, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL sb_single: got kind=%0d cyc=%0d err=%0d, want kind=%0d cyc=%0d err=%0d",
                             o.kind, o.cyc, o.err, e.kind, e.cyc, e.err);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_single_extra: got %0d extra events, want 0", obs_q.size());
        end
    endtask

    task automatic test_burst_spacing();
        int  k;
        ev_t e, o;
        exp_q.delete();
        obs_q.delete();
        bsync_ratio = 16'd10;
        wait_pcnt(2);
        k = cyc;
        req = 1'b1; req_count = 8'd3; req_interval = 16'd4;
        exp_q.push_back(mk_ev(EV_ACK, k + 1, 2'd0));
        exp_q.push_back(mk_ev(EV_TRIG, k + 8, 2'd0));
        exp_q.push_back(mk_ev(EV_TRIG, k + 48, 2'd0));
        exp_q.push_back(mk_ev(EV_TRIG, k + 88, 2'd0));
        exp_q.push_back(mk_ev(EV_DONE, k + 89, 2'd0));
        step();
        req = 1'b0;
        while (cyc < k + 100) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_spacing: got nothing, want kind=%0d cyc=%0d err=%0d", e.kind, e.cyc, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL sb_spacing: got kind=%0d cyc=%0d err=%0d, want kind=%0d cyc=%0d err=%0d",
                             o.kind, o.cyc, o.err, e.kind, e.cyc, e.err);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_spacing_extra: got %0d extra events, want 0", obs_q.size());
        end
    endtask

    task automatic test_zero_count();
        int  k;
        ev_t e, o;
        exp_q.delete();
        obs_q.delete();
        wait_pcnt(5);
        k = cyc;
        req = 1'b1; req_count = 8'd0; req_interval = 16'd3;
        exp_q.push_back(mk_ev(EV_ACK, k + 1, 2'd0));
        exp_q.push_back(mk_ev(EV_DONE, k + 2, 2'd0));
        step();
        req = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_busy: busy=%b, want 1", busy);
        end
        while (cyc < k + 25) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_zero: got nothing, want kind=%0d cyc=%0d err=%0d", e.kind, e.cyc, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL sb_zero: got kind=%0d cyc=%0d err=%0d, want kind=%0d cyc=%0d err=%0d",
                             o.kind, o.cyc, o.err, e.kind, e.cyc, e.err);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_zero_extra: got %0d extra events, want 0", obs_q.size());
        end
    endtask

    task automatic test_update_collision();
        int  k, j;
        ev_t e, o;
        logic [NUM_CH*PH_W-1:0] ph1, ph2;
        ph1 = {16'hA5A5, 16'h0F0F, 16'h7777, 16'h0123};
        ph2 = {16'hA5A5, 16'h0F0F, 16'h7777, 16'h4567};
        exp_q.delete();
        obs_q.delete();
        bsync_ratio = 16'd8;
        wait_pcnt(2);
        k = cyc;
        req = 1'b1; req_count = 8'd2; req_interval = 16'd2;
        cfg_en = 4'b1011;
        cfg_phase = ph1;
        exp_q.push_back(mk_ev(EV_ACK, k + 1, 2'd0));
        exp_q.push_back(mk_ev(EV_TRIG, k + 6, 2'd0));
        exp_q.push_back(mk_ev(EV_TRIG, k + 22, 2'd0));
        exp_q.push_back(mk_ev(EV_DONE, k + 23, 2'd0));
        step();
        req = 1'b0;
        step();
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        while (cyc < k + 30) begin
            step();
            if (cyc == k + 6) begin
                n_cmp++;
                if ({trigger, ch_en, ch_phase} !== {1'b1, 4'b0000, 64'h0}) begin
                    n_bad++;
                    $display("FAIL upd_at_fire: trig=%b en=%b phase=%h, want trig=1 en=0 phase=0",
                             trigger, ch_en, ch_phase);
                end
            end else if (cyc == k + 13) begin
                n_cmp++;
                if (ch_phase !== 64'h0) begin
                    n_bad++;
                    $display("FAIL upd_before_tick: phase=%h, want 0", ch_phase);
                end
            end else if (cyc == k + 14) begin
                n_cmp++;
                if ({ch_en, ch_phase} !== {4'b1011, ph1}) begin
                    n_bad++;
                    $display("FAIL upd_applied: en=%b phase=%h, want en=1011 phase=%h", ch_en, ch_phase, ph1);
                end
            end
        end
        // Idle update: applied the cycle after upd_pend is set.
        j = cyc;
        cfg_phase = ph2;
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        n_cmp++;
        if (ch_phase !== ph1) begin
            n_bad++;
            $display("FAIL upd_idle_early: phase=%h, want %h (cyc %0d)", ch_phase, ph1, j + 1);
        end
        step();
        n_cmp++;
        if (ch_phase !== ph2) begin
            n_bad++;
            $display("FAIL upd_idle_apply: phase=%h, want %h", ch_phase, ph2);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_update: got nothing, want kind=%0d cyc=%0d err=%0d", e.kind, e.cyc, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL sb_update: got kind=%0d cyc=%0d err=%0d, want kind=%0d cyc=%0d err=%0d",
                             o.kind, o.cyc, o.err, e.kind, e.cyc, e.err);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_update_extra: got %0d extra events, want 0", obs_q.size());
        end
    endtask

    task automatic test_faults();
        int  k;
        ev_t e, o;
        exp_q.delete();
        obs_q.delete();
        // BSYNC lost while waiting in GAP.
        bsync_ratio = 16'd8;
        wait_pcnt(2);
        k = cyc;
        req = 1'b1; req_count = 8'd3; req_interval = 16'd2;
        exp_q.push_back(mk_ev(EV_ACK, k + 1, 2'd0));
        exp_q.push_back(mk_ev(EV_TRIG, k + 6, 2'd0));
        exp_q.push_back(mk_ev(EV_DONE, k + 11, 2'd1));
        step();
        req = 1'b0;
        while (cyc < k + 9) step();
        bsync_ready = 1'b0;
        while (cyc < k + 30) step();
        bsync_ready = 1'b1;
        repeat (3) step();
        // Abort on the very tick that would fire.
        wait_pcnt(2);
        k = cyc;
        req = 1'b1; req_count = 8'd1; req_interval = 16'd1;
        exp_q.push_back(mk_ev(EV_ACK, k + 1, 2'd0));
        exp_q.push_back(mk_ev(EV_DONE, k + 7, 2'd2));
        step();
        req = 1'b0;
        while (cyc < k + 5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        while (cyc < k + 20) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_faults: got nothing, want kind=%0d cyc=%0d err=%0d", e.kind, e.cyc, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL sb_faults: got kind=%0d cyc=%0d err=%0d, want kind=%0d cyc=%0d err=%0d",
                             o.kind, o.cyc, o.err, e.kind, e.cyc, e.err);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_faults_extra: got %0d extra events, want 0", obs_q.size());
        end
    endtask

    task automatic test_ratio_guard_reset();
        int  k;
        ev_t e, o;
        logic [NUM_CH*PH_W+NUM_CH+5:0] v;
        exp_q.delete();
        obs_q.delete();
        bsync_ratio = 16'd1;
        req = 1'b1; req_count = 8'd2; req_interval = 16'd1;
        repeat (10) step();
        n_cmp++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL guard_no_ack: events=%0d busy=%b, want events=0 busy=0", obs_q.size(), busy);
        end
        k = cyc;
        bsync_ratio = 16'd4;
        exp_q.push_back(mk_ev(EV_ACK, k + 1, 2'd0));
        exp_q.push_back(mk_ev(EV_TRIG, k + 4, 2'd0));
        step();
        req = 1'b0;
        while (cyc < k + 5) step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL guard_busy_gap: busy=%b, want 1", busy);
        end
        // Asynchronous reset in the middle of a clock period.
        #2;
        rstn = 1'b0;
        #1;
        v = {ack, trigger, busy, done, err, ch_en, ch_phase};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %h, want 0", v);
        end
        repeat (3) step();
        rstn = 1'b1;
        repeat (12) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_guard: got nothing, want kind=%0d cyc=%0d err=%0d", e.kind, e.cyc, e.err);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL sb_guard: got kind=%0d cyc=%0d err=%0d, want kind=%0d cyc=%0d err=%0d",
                             o.kind, o.cyc, o.err, e.kind, e.cyc, e.err);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_guard_extra: got %0d extra events (no done after reset), want 0", obs_q.size());
        end
    endtask

    initial begin
        rstn         = 1'b0;
        bsync_ready  = 1'b1;
        bsync_ratio  = 16'd8;
        cfg_en       = '0;
        cfg_phase    = '0;
        cfg_update   = 1'b0;
        req          = 1'b0;
        req_count    = 8'd0;
        req_interval = '0;
        abort        = 1'b0;

        test_reset();
        test_single_burst();
        test_burst_spacing();
        test_zero_count();
        test_update_collision();
        test_faults();
        test_ratio_guard_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
